tt_cpu_io_bridge: RTL and testbench
===================================

# tt_cpu_io_bridge

Pin-side front end between the TinyTapeout IO ring and the pipelined RISC-V core. It assembles byte-wide pin writes into full instruction words for program memory, with an auto-incrementing address pointer. It holds the core in reset while loading and presents a selectable byte of the core's result on `uo_out`. It is a generalised successor to the direct-pin loading scheme: parametrised data and address widths, a strobe handshake, status outputs and mode control.

## Interface
Parameters:
- `DATA_WIDTH`, 32: program-memory word and result width; must be a multiple of `IN_WIDTH`.
- `ADD_WIDTH`, 7: program-memory address width; must be ≤ `IN_WIDTH`.
- `IN_WIDTH`, 8: pin byte width; `BYTES = DATA_WIDTH/IN_WIDTH`, max 4.

Ports (one clock; reset is asynchronous, active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `ui_in` in 8: load data byte / address value.
- `uio_in` in 8: [7:6] mode, [5] strobe, [4:3] result byte select; [2:0] unused.
- `uo_out` out 8: display byte.
- `uio_out` out 8: [0] word_pending, [1] cpu_running, [2] addr_wrapped; [7:3] = 0.
- `uio_oe` out 8: constant 8'h07.
- `cpu_result` in `DATA_WIDTH`: ALU result from the core.
- `cpu_rst_n` out 1: core reset, active-low.
- `pm_wr_en` out 1: program-memory write, one-cycle pulse.
- `pm_addr` out `ADD_WIDTH`: program-memory write address.
- `pm_wdata` out `DATA_WIDTH`: program-memory write data.

## Operation
- Modes: 00 RUN, 01 LOAD, 10 SET_ADDR, 11 HOLD.
- Input synchronisation: `ui_in`, mode and strobe each pass through the same two-flop synchroniser. A strobe event is a rising edge on the synchronised strobe.
- LOAD strobe:
  - The byte shifts into the word buffer, first byte least significant; `byte_cnt` increments.
  - When byte `BYTES` arrives, the buffer copies to `pm_wdata`, `pm_wr_en` pulses with `pm_addr` = pointer, the pointer increments and `byte_cnt` clears.
- SET_ADDR strobe: pointer ← `ui_in[ADD_WIDTH-1:0]`; `byte_cnt` and `addr_wrapped` clear.
- HOLD strobe: `cpu_result` is captured into the snapshot register.
- Pointer wrap: 2^`ADD_WIDTH`−1 wraps to 0 and sets `addr_wrapped` (sticky until SET_ADDR or reset).
- Leaving LOAD with a partial word discards it; `byte_cnt` clears. Strobes in RUN are ignored.
- `cpu_rst_n` is registered; it is 1 only while the synchronised mode is RUN.
- `uo_out` source by mode:
  - RUN: live byte `uio_in[4:3]` of `cpu_result`.
  - HOLD: that byte of the snapshot register.
  - LOAD: {`byte_cnt`, zeros}.
  - SET_ADDR: pointer zero-extended.
  - A select index ≥ `BYTES` gives 0. `uo_out` is registered.
- `word_pending` = (`byte_cnt` ≠ 0).

## Timing
- Reset values: `uo_out` 0, `uio_out` 0, `pm_wr_en` 0, `pm_addr` 0, `pm_wdata` 0, `cpu_rst_n` 0, pointer 0, snapshot 0, `byte_cnt` 0.
- Strobe latency: a strobe first sampled high at edge k causes its action at edge k+2.
- Write latency: `pm_wr_en` and the final `pm_wdata`/`pm_addr` are valid from edge k+2 to k+3 for the last byte; the pointer shows +1 from edge k+3.
- Strobe spacing: strobes at least 4 cycles apart are each accepted. A strobe low pulse of less than 2 cycles may merge with the next strobe.
- Pin setup: mode and data must be stable 3 cycles before strobe rise.
- A new byte may arrive while `pm_wr_en` is high; the buffer and `pm_wdata` are independent.
- Mode change and strobe on the same synchronised cycle: the new mode governs.
- Core release: `cpu_rst_n` rises 3 edges after the mode pin goes to RUN and falls 3 edges after the mode pin leaves RUN.
- Reset mid-load: all state clears immediately; no write is issued.

## Configuration
- `TT_IOBRIDGE_CKSUM_EN` defined: an 8-bit XOR checksum of every byte accepted in LOAD, cleared by SET_ADDR or reset. `uo_out` shows it in HOLD when `uio_in[4:3]` = 3.
- `TT_IOBRIDGE_CKSUM_EN` undefined: no checksum register; HOLD behaviour follows the normal select rules.

## Structure
- Package `tt_iobridge_pkg`: mode constants (RUN/LOAD/SET_ADDR/HOLD), the `BYTES` derivation function and uio bit-index constants.
- Sub-module `tt_pin_sync`: parametrised-width two-flop synchroniser, instantiated for `{strobe, mode, ui_in}`. Edge detection lives in the top.

## Test plan
- Reset, then LOAD with bytes 0x13, 0x05, 0x10, 0x00 → one `pm_wr_en` pulse with `pm_addr` = 0 and `pm_wdata` = 0x00100513; pointer then 1.
- SET_ADDR `ui_in` = 0x7F, then LOAD 8 bytes → writes at 0x7F and 0x00; `addr_wrapped` = 1.
- LOAD 2 bytes, switch to RUN → no write; `word_pending` 1 → 0; `cpu_rst_n` rises 3 cycles after the mode pin changes.
- RUN with `cpu_result` = 0xDEADBEEF and select 0..3 → `uo_out` = EF, BE, AD, DE; HOLD strobe, then change `cpu_result` → held value still shown.
- Assert `rst_n` low during the third byte of a word → all outputs 0, no pulse; after release, a fresh 4-byte load writes address 0.
- With `TT_IOBRIDGE_CKSUM_EN`, load 0x13, 0x05, 0x10, 0x00 → HOLD select 3 shows 0x06.

Source files
------------

// File: rtl/tt_iobridge_pkg.sv
// -----------------------------------------------------------------------------
// tt_iobridge_pkg
// Shared definitions for the TinyTapeout CPU IO bridge:
//   - mode_e        : pin-selected operating mode (RUN / LOAD / SET_ADDR / HOLD)
//   - calc_bytes    : number of pin bytes that make up one program-memory word
//   - cksum_update  : running XOR checksum step for loaded bytes
//   - UIO_*         : bit positions inside uio_in / uio_out
// -----------------------------------------------------------------------------
package tt_iobridge_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_LOAD     = 2'b01,
        MODE_SET_ADDR = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    // uio_in field positions
    localparam int UIO_MODE_HI = 7;
    localparam int UIO_MODE_LO = 6;
    localparam int UIO_STROBE  = 5;
    localparam int UIO_SEL_HI  = 4;
    localparam int UIO_SEL_LO  = 3;

    // uio_out status bit positions
    localparam int UIO_PENDING = 0;
    localparam int UIO_RUNNING = 1;
    localparam int UIO_WRAPPED = 2;

    // Pin bytes per program-memory word (first byte is least significant).
    function automatic int calc_bytes(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction

    // One step of the 8-bit XOR checksum over accepted load bytes.
    function automatic logic [7:0] cksum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/tt_cpu_io_bridge_if.sv
// -----------------------------------------------------------------------------
// tt_cpu_io_bridge_if
// Pin-ring and core-side signal bundle of the bridge.
//   ui_in, uio_in, cpu_result          : into the bridge
//   uo_out, uio_out, uio_oe,
//   cpu_rst_n, pm_wr_en, pm_addr,
//   pm_wdata                           : out of the bridge
// modport slave  : the bridge itself
// modport master : the environment (IO ring + core) driving the bridge
// -----------------------------------------------------------------------------
interface tt_cpu_io_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 7
);
    logic [7:0]            ui_in;
    logic [7:0]            uio_in;
    logic [7:0]            uo_out;
    logic [7:0]            uio_out;
    logic [7:0]            uio_oe;
    logic [DATA_WIDTH-1:0] cpu_result;
    logic                  cpu_rst_n;
    logic                  pm_wr_en;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic [DATA_WIDTH-1:0] pm_wdata;

    modport slave (
        input  ui_in, uio_in, cpu_result,
        output uo_out, uio_out, uio_oe, cpu_rst_n, pm_wr_en, pm_addr, pm_wdata
    );

    modport master (
        output ui_in, uio_in, cpu_result,
        input  uo_out, uio_out, uio_oe, cpu_rst_n, pm_wr_en, pm_addr, pm_wdata
    );
endinterface

// File: rtl/tt_pin_sync.sv
// -----------------------------------------------------------------------------
// tt_pin_sync
// Parametrised-width two-flop synchroniser for asynchronous pin inputs.
//   clk, rst_n : clock, async active-low reset
//   d_i        : raw pin bits
//   q_o        : synchronised bits (two clock edges of latency)
// RST_VAL lets the caller choose a safe value to present while reset is held.
// -----------------------------------------------------------------------------
module tt_pin_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state of the two synchroniser stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tt_cpu_io_bridge.sv
// -----------------------------------------------------------------------------
// tt_cpu_io_bridge
// Pin-side front end between the TinyTapeout IO ring and the RISC-V core.
// Assembles pin bytes into program-memory words with an auto-incrementing
// pointer, holds the core in reset unless in RUN, and shows a selectable byte
// of the core result (live or snapshotted) on uo_out.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : tt_cpu_io_bridge_if.slave
//                ui_in    - load byte / address value
//                uio_in   - [7:6] mode, [5] strobe, [4:3] result byte select
//                uo_out   - display byte (registered)
//                uio_out  - [0] word_pending [1] cpu_running [2] addr_wrapped
//                uio_oe   - constant 8'h07
//                cpu_result, cpu_rst_n, pm_wr_en, pm_addr, pm_wdata
//
// Optional feature macro: TT_IOBRIDGE_CKSUM_EN
//   defined   - 8-bit XOR checksum of loaded bytes, shown in HOLD with select 3
//   undefined - no checksum register
// -----------------------------------------------------------------------------
module tt_cpu_io_bridge
    import tt_iobridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 7,
    parameter int IN_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    tt_cpu_io_bridge_if.slave   bus
);

    localparam int         BYTES    = calc_bytes(DATA_WIDTH, IN_WIDTH);
    localparam int         SYNC_W   = 1 + 2 + IN_WIDTH;
    localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);
    // While reset is held the synchronised mode reads HOLD so the core is
    // never released and no byte can be loaded by a stale strobe.
    localparam logic [SYNC_W-1:0] SYNC_RST = {1'b0, MODE_HOLD, {IN_WIDTH{1'b0}}};

    // ---------------------------------------------------------------- sync
    logic [SYNC_W-1:0]   sync_out_s;
    logic                strobe_s;
    mode_e               mode_s;
    logic [IN_WIDTH-1:0] data_s;
    logic                strobe_rise_s;
    logic [1:0]          sel_s;
    logic                unused_pins_s;

    tt_pin_sync #(
        .WIDTH   (SYNC_W),
        .RST_VAL (SYNC_RST)
    ) u_pin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({bus.uio_in[UIO_STROBE], bus.uio_in[UIO_MODE_HI:UIO_MODE_LO],
                 bus.ui_in[IN_WIDTH-1:0]}),
        .q_o   (sync_out_s)
    );

    assign strobe_s      = sync_out_s[SYNC_W-1];
    assign mode_s        = mode_e'(sync_out_s[SYNC_W-2:SYNC_W-3]);
    assign data_s        = sync_out_s[IN_WIDTH-1:0];
    // The select only steers an output mux, so it is used without synchronising.
    assign sel_s         = bus.uio_in[UIO_SEL_HI:UIO_SEL_LO];
    assign unused_pins_s = ^bus.uio_in[2:0];

    // --------------------------------------------------------------- state
    logic                  strobe_prev_q, strobe_prev_d;
    logic [1:0]            byte_cnt_q,    byte_cnt_d;
    logic [DATA_WIDTH-1:0] wbuf_q,        wbuf_d;
    logic [ADD_WIDTH-1:0]  pointer_q,     pointer_d;
    logic                  wrapped_q,     wrapped_d;
    logic                  pm_wr_en_q,    pm_wr_en_d;
    logic [ADD_WIDTH-1:0]  pm_addr_q,     pm_addr_d;
    logic [DATA_WIDTH-1:0] pm_wdata_q,    pm_wdata_d;
    logic [DATA_WIDTH-1:0] snapshot_q,    snapshot_d;
    logic                  cpu_rst_n_q,   cpu_rst_n_d;
    logic [7:0]            uo_out_q,      uo_out_d;
    logic [7:0]            uio_out_q,     uio_out_d;
    logic [DATA_WIDTH-1:0] shifted_s;
`ifdef TT_IOBRIDGE_CKSUM_EN
    logic [7:0]            cksum_q,       cksum_d;
`endif

    assign strobe_rise_s = strobe_s & ~strobe_prev_q;
    // New byte enters at the top so that after BYTES shifts the first byte is LSB.
    assign shifted_s = (wbuf_q >> IN_WIDTH) | (DATA_WIDTH'(data_s) << (DATA_WIDTH - IN_WIDTH));

    // Byte lanes of the live result and the snapshot; lanes beyond BYTES read 0.
    logic [IN_WIDTH-1:0] live_bytes_s [4];
    logic [IN_WIDTH-1:0] held_bytes_s [4];
    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g < BYTES) begin : g_used
            assign live_bytes_s[g] = bus.cpu_result[g*IN_WIDTH +: IN_WIDTH];
            assign held_bytes_s[g] = snapshot_q[g*IN_WIDTH +: IN_WIDTH];
        end else begin : g_unused
            assign live_bytes_s[g] = '0;
            assign held_bytes_s[g] = '0;
        end
    end

    // Mode-dependent next-state: loading, pointer control and snapshot capture.
    always_comb begin
        strobe_prev_d = strobe_s;
        byte_cnt_d    = byte_cnt_q;
        wbuf_d        = wbuf_q;
        pointer_d     = pointer_q;
        wrapped_d     = wrapped_q;
        pm_wr_en_d    = 1'b0;
        pm_addr_d     = pm_addr_q;
        pm_wdata_d    = pm_wdata_q;
        snapshot_d    = snapshot_q;
        cpu_rst_n_d   = (mode_s == MODE_RUN);
`ifdef TT_IOBRIDGE_CKSUM_EN
        cksum_d       = cksum_q;
`endif
        case (mode_s)
            MODE_LOAD: begin
                if (strobe_rise_s) begin
                    wbuf_d = shifted_s;
`ifdef TT_IOBRIDGE_CKSUM_EN
                    cksum_d = cksum_update(cksum_q, 8'(data_s));
`endif
                    if (byte_cnt_q == LAST_IDX) begin
                        pm_wr_en_d = 1'b1;
                        pm_wdata_d = shifted_s;
                        pm_addr_d  = pointer_q;
                        pointer_d  = pointer_q + ADD_WIDTH'(1);
                        byte_cnt_d = 2'd0;
                        // Sticky: only SET_ADDR or reset clears it.
                        if (pointer_q == {ADD_WIDTH{1'b1}}) begin
                            wrapped_d = 1'b1;
                        end else begin
                            wrapped_d = wrapped_q;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            MODE_SET_ADDR: begin
                byte_cnt_d = 2'd0;
                if (strobe_rise_s) begin
                    pointer_d = data_s[ADD_WIDTH-1:0];
                    wrapped_d = 1'b0;
`ifdef TT_IOBRIDGE_CKSUM_EN
                    cksum_d   = 8'h00;
`endif
                end else begin
                    pointer_d = pointer_q;
                end
            end
            MODE_HOLD: begin
                byte_cnt_d = 2'd0;
                if (strobe_rise_s) begin
                    snapshot_d = bus.cpu_result;
                end else begin
                    snapshot_d = snapshot_q;
                end
            end
            default: begin
                // RUN: strobes ignored, any partial word dropped.
                byte_cnt_d = 2'd0;
            end
        endcase
        uio_out_d = {5'b00000, wrapped_d, cpu_rst_n_d, (byte_cnt_d != 2'd0)};
    end

    // Display byte selection.
    always_comb begin
        uo_out_d = 8'h00;
        case (mode_s)
            MODE_RUN:      uo_out_d = 8'(live_bytes_s[sel_s]);
            MODE_HOLD: begin
`ifdef TT_IOBRIDGE_CKSUM_EN
                if (sel_s == 2'd3) begin
                    uo_out_d = cksum_q;
                end else begin
                    uo_out_d = 8'(held_bytes_s[sel_s]);
                end
`else
                uo_out_d = 8'(held_bytes_s[sel_s]);
`endif
            end
            MODE_LOAD:     uo_out_d = {byte_cnt_q, 6'b000000};
            MODE_SET_ADDR: uo_out_d = 8'(pointer_q);
            default:       uo_out_d = 8'h00;
        endcase
    end

    // Bridge state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev_q <= 1'b0;
            byte_cnt_q    <= 2'd0;
            wbuf_q        <= '0;
            pointer_q     <= '0;
            wrapped_q     <= 1'b0;
            pm_wr_en_q    <= 1'b0;
            pm_addr_q     <= '0;
            pm_wdata_q    <= '0;
            snapshot_q    <= '0;
            cpu_rst_n_q   <= 1'b0;
            uo_out_q      <= 8'h00;
            uio_out_q     <= 8'h00;
        end else begin
            strobe_prev_q <= strobe_prev_d;
            byte_cnt_q    <= byte_cnt_d;
            wbuf_q        <= wbuf_d;
            pointer_q     <= pointer_d;
            wrapped_q     <= wrapped_d;
            pm_wr_en_q    <= pm_wr_en_d;
            pm_addr_q     <= pm_addr_d;
            pm_wdata_q    <= pm_wdata_d;
            snapshot_q    <= snapshot_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
            uo_out_q      <= uo_out_d;
            uio_out_q     <= uio_out_d;
        end
    end

`ifdef TT_IOBRIDGE_CKSUM_EN
    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= 8'h00;
        end else begin
            cksum_q <= cksum_d;
        end
    end
`endif

    assign bus.uo_out    = uo_out_q;
    assign bus.uio_out   = uio_out_q;
    assign bus.uio_oe    = 8'h07;
    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.pm_wr_en  = pm_wr_en_q;
    assign bus.pm_addr   = pm_addr_q;
    assign bus.pm_wdata  = pm_wdata_q;

endmodule

// File: tb/tb_tt_cpu_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_tt_cpu_io_bridge
// Directed self-checking bench for tt_cpu_io_bridge. Inputs change on the
// falling edge, outputs are sampled on the falling edge. A monitor records
// every cycle in which pm_wr_en is high.
// -----------------------------------------------------------------------------
module tb_tt_cpu_io_bridge;

    localparam logic [1:0] M_RUN  = 2'b00;
    localparam logic [1:0] M_LOAD = 2'b01;
    localparam logic [1:0] M_SET  = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode_v;
    logic       strobe_v;
    logic [1:0] sel_v;
    int         checks;
    int         errors;

    logic [6:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    tt_cpu_io_bridge_if #(.DATA_WIDTH(32), .ADD_WIDTH(7)) bus ();

    assign bus.uio_in = {mode_v, strobe_v, sel_v, 3'b000};

    tt_cpu_io_bridge #(
        .DATA_WIDTH (32),
        .ADD_WIDTH  (7),
        .IN_WIDTH   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Write monitor: one entry per cycle with pm_wr_en high.
    always @(posedge clk) begin
        #1;
        if (bus.pm_wr_en === 1'b1) begin
            wr_addr_q.push_back(bus.pm_addr);
            wr_data_q.push_back(bus.pm_wdata);
        end
    end

    task automatic set_mode(input logic [1:0] m);
        mode_v = m;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] b);
        bus.ui_in = b;
        repeat (3) @(negedge clk);
        strobe_v = 1'b1;
        repeat (2) @(negedge clk);
        strobe_v = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h want 00", bus.uo_out); end
        checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out); end
        checks++; if (bus.uio_oe !== 8'h07) begin errors++; $display("FAIL reset_uio_oe: got %h want 07", bus.uio_oe); end
        checks++; if ({bus.pm_wr_en, bus.cpu_rst_n, bus.pm_addr} !== 9'h000) begin errors++;
            $display("FAIL reset_ctrl: got wr=%b rst=%b addr=%h want 0", bus.pm_wr_en, bus.cpu_rst_n, bus.pm_addr); end
        checks++; if (bus.pm_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.pm_wdata); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_held: got %b want 0", bus.cpu_rst_n); end
    endtask

    task automatic test_load_word();
        logic [6:0]  a;
        logic [31:0] d;
        set_mode(M_LOAD);
        pulse(8'h13);
        pulse(8'h05);
        checks++; if (bus.uo_out !== 8'h80) begin errors++; $display("FAIL load_cnt_display: got %h want 80", bus.uo_out); end
        checks++; if (bus.uio_out !== 8'h01) begin errors++; $display("FAIL load_pending: got %h want 01", bus.uio_out); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL load_early_write: got %0d writes want 0", wr_addr_q.size()); end
        pulse(8'h10);
        pulse(8'h00);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL load_write_count: got %0d want 1", wr_addr_q.size()); end
        a = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 7'hxx;
        d = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx;
        checks++; if (a !== 7'h00) begin errors++; $display("FAIL load_addr: got %h want 00", a); end
        checks++; if (d !== 32'h00100513) begin errors++; $display("FAIL load_data: got %h want 00100513", d); end
        checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL load_done_status: got %h want 00", bus.uio_out); end
        wr_addr_q.delete(); wr_data_q.delete();
        set_mode(M_SET);
        checks++; if (bus.uo_out !== 8'h01) begin errors++; $display("FAIL load_pointer: got %h want 01", bus.uo_out); end
    endtask

    task automatic test_wrap();
        logic [6:0]  a0, a1;
        logic [31:0] d0, d1;
        pulse(8'h7F);
        checks++; if (bus.uo_out !== 8'h7F) begin errors++; $display("FAIL wrap_setaddr: got %h want 7f", bus.uo_out); end
        set_mode(M_LOAD);
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
        pulse(8'h55); pulse(8'h66); pulse(8'h77); pulse(8'h88);
        checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL wrap_write_count: got %0d want 2", wr_addr_q.size()); end
        a0 = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 7'hxx;
        a1 = (wr_addr_q.size() > 1) ? wr_addr_q[1] : 7'hxx;
        d0 = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx;
        d1 = (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hxxxxxxxx;
        checks++; if ({a0, a1} !== {7'h7F, 7'h00}) begin errors++; $display("FAIL wrap_addrs: got %h,%h want 7f,00", a0, a1); end
        checks++; if ({d0, d1} !== {32'h44332211, 32'h88776655}) begin errors++; $display("FAIL wrap_data: got %h,%h want 44332211,88776655", d0, d1); end
        checks++; if (bus.uio_out !== 8'h04) begin errors++; $display("FAIL wrap_flag: got %h want 04", bus.uio_out); end
        wr_addr_q.delete(); wr_data_q.delete();
        set_mode(M_SET);
        checks++; if (bus.uo_out !== 8'h01) begin errors++; $display("FAIL wrap_pointer: got %h want 01", bus.uo_out); end
        pulse(8'h00);
        checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL wrap_clear: got %h want 00", bus.uio_out); end
    endtask

    task automatic test_partial_abort();
        set_mode(M_LOAD);
        pulse(8'hAA);
        pulse(8'hBB);
        checks++; if (bus.uio_out !== 8'h01) begin errors++; $display("FAIL abort_pending: got %h want 01", bus.uio_out); end
        mode_v = M_RUN;
        repeat (2) @(negedge clk);
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL abort_core_early: got %b want 0", bus.cpu_rst_n); end
        @(negedge clk);
        checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL abort_core_release: got %b want 1", bus.cpu_rst_n); end
        checks++; if (bus.uio_out !== 8'h02) begin errors++; $display("FAIL abort_status: got %h want 02", bus.uio_out); end
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL abort_no_write: got %0d writes want 0", wr_addr_q.size()); end
    endtask

    task automatic test_run_hold();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        bus.cpu_result = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            sel_v = 2'(i);
            @(negedge clk);
            checks++; if (bus.uo_out !== exp_b[i]) begin errors++; $display("FAIL run_sel%0d: got %h want %h", i, bus.uo_out, exp_b[i]); end
        end
        sel_v = 2'd1;
        mode_v = M_HOLD;
        repeat (2) @(negedge clk);
        checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL hold_core_early: got %b want 1", bus.cpu_rst_n); end
        @(negedge clk);
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL hold_core_reset: got %b want 0", bus.cpu_rst_n); end
        checks++; if (bus.uo_out !== 8'h00) begin errors++; $display("FAIL hold_empty_snapshot: got %h want 00", bus.uo_out); end
        pulse(8'h00);
        bus.cpu_result = 32'h12345678;
        sel_v = 2'd2;
        repeat (2) @(negedge clk);
        checks++; if (bus.uo_out !== 8'hAD) begin errors++; $display("FAIL hold_sel2: got %h want ad", bus.uo_out); end
        sel_v = 2'd0;
        repeat (2) @(negedge clk);
        checks++; if (bus.uo_out !== 8'hEF) begin errors++; $display("FAIL hold_sel0: got %h want ef", bus.uo_out); end
    endtask

    task automatic test_reset_mid_load();
        logic [6:0]  a;
        logic [31:0] d;
        set_mode(M_LOAD);
        pulse(8'h0A); pulse(8'h0B); pulse(8'h0C); pulse(8'h0D);
        pulse(8'hE1); pulse(8'hE2);
        bus.ui_in = 8'hE3;
        repeat (3) @(negedge clk);
        strobe_v = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.uo_out, bus.uio_out} !== 16'h0000) begin errors++; $display("FAIL rst_mid_pins: got %h %h want 00 00", bus.uo_out, bus.uio_out); end
        checks++; if ({bus.pm_wr_en, bus.cpu_rst_n, bus.pm_addr, bus.pm_wdata} !== 41'h0) begin errors++;
            $display("FAIL rst_mid_core: got wr=%b rst=%b addr=%h data=%h want 0", bus.pm_wr_en, bus.cpu_rst_n, bus.pm_addr, bus.pm_wdata); end
        @(negedge clk);
        strobe_v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL rst_mid_write_count: got %0d want 1", wr_addr_q.size()); end
        d = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx;
        checks++; if (d !== 32'h0D0C0B0A) begin errors++; $display("FAIL rst_mid_first_word: got %h want 0d0c0b0a", d); end
        wr_addr_q.delete(); wr_data_q.delete();
        pulse(8'h01); pulse(8'h02); pulse(8'h03); pulse(8'h04);
        a = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 7'hxx;
        d = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx;
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL rst_after_count: got %0d want 1", wr_addr_q.size()); end
        checks++; if (a !== 7'h00) begin errors++; $display("FAIL rst_after_addr: got %h want 00", a); end
        checks++; if (d !== 32'h04030201) begin errors++; $display("FAIL rst_after_data: got %h want 04030201", d); end
        wr_addr_q.delete(); wr_data_q.delete();
    endtask

    task automatic test_cksum();
        logic [7:0] exp_sel3;
        set_mode(M_SET);
        pulse(8'h00);
        set_mode(M_LOAD);
        pulse(8'h13); pulse(8'h05); pulse(8'h10); pulse(8'h00);
        checks++; if (bus.pm_wdata !== 32'h00100513) begin errors++; $display("FAIL cksum_word: got %h want 00100513", bus.pm_wdata); end
        set_mode(M_HOLD);
        bus.cpu_result = 32'hA1B2C3D4;
        pulse(8'h00);
        sel_v = 2'd3;
        repeat (2) @(negedge clk);
`ifdef TT_IOBRIDGE_CKSUM_EN
        exp_sel3 = 8'h06;
`else
        exp_sel3 = 8'hA1;
`endif
        checks++; if (bus.uo_out !== exp_sel3) begin errors++; $display("FAIL hold_sel3: got %h want %h", bus.uo_out, exp_sel3); end
    endtask

    initial begin
        clk            = 1'b0;
        rst_n          = 1'b0;
        mode_v         = M_LOAD;
        strobe_v       = 1'b0;
        sel_v          = 2'd0;
        bus.ui_in      = 8'h00;
        bus.cpu_result = 32'h0;
        checks         = 0;
        errors         = 0;
        test_reset();
        test_load_word();
        test_wrap();
        test_partial_abort();
        test_run_hold();
        test_reset_mid_load();
        test_cksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
